// File: rtl/adpcm_addb.sv
// G.726 ADDB reconstruction adder: SR = DQ (sign-magnitude) + SE (two's complement),
// 16-bit wrap-around, registered with one cycle of latency.
module adpcm_addb (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] dq,
   input  logic [14:0] se,
   output logic [15:0] sr,
   input  logic        scan_in0,
   input  logic        scan_in1,
   input  logic        scan_in2,
   input  logic        scan_in3,
   input  logic        scan_in4,
   input  logic        scan_enable,
   input  logic        test_mode,
   output logic        scan_out0,
   output logic        scan_out1,
   output logic        scan_out2,
   output logic        scan_out3,
   output logic        scan_out4
);

   logic [15:0] dqi;
   logic [15:0] sei;
   logic [15:0] sr_d;
   logic [15:0] sr_q;
   logic        unused_dft;

   // Negative zero (8000) negates a zero magnitude, so it maps to 0 rather than -32768.
   always_comb begin
      dqi  = dq[15] ? (16'h0000 - {1'b0, dq[14:0]}) : dq;
      sei  = {se[14], se};
      sr_d = dqi + sei;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr_q <= 16'h0000;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign sr = sr_q;

   // Scan chains are inserted later by the DFT flow; the RTL only ties the outputs off.
   assign scan_out0  = 1'b0;
   assign scan_out1  = 1'b0;
   assign scan_out2  = 1'b0;
   assign scan_out3  = 1'b0;
   assign scan_out4  = 1'b0;
   assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};

endmodule

// File: tb/tb_adpcm_addb.sv
// Self-checking bench for adpcm_addb: directed G.726 vectors, async reset cases,
// and randomized vectors checked every cycle against an integer arithmetic model.
module tb_adpcm_addb;

   logic        clk;
   logic        reset;
   logic [15:0] dq;
   logic [14:0] se;
   logic [15:0] sr;
   logic        scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
   logic        scan_enable, test_mode;
   logic        scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

   int tests;
   int fails;
   logic [15:0] expected;
   logic        chk_en;

   adpcm_addb dut (
      .clk        (clk),
      .reset      (reset),
      .dq         (dq),
      .se         (se),
      .sr         (sr),
      .scan_in0   (scan_in0),
      .scan_in1   (scan_in1),
      .scan_in2   (scan_in2),
      .scan_in3   (scan_in3),
      .scan_in4   (scan_in4),
      .scan_enable(scan_enable),
      .test_mode  (test_mode),
      .scan_out0  (scan_out0),
      .scan_out1  (scan_out1),
      .scan_out2  (scan_out2),
      .scan_out3  (scan_out3),
      .scan_out4  (scan_out4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decode both operands to signed integers, add, keep the low 16 bits.
   function automatic logic [15:0] addb_model(input logic [15:0] d, input logic [14:0] s);
      int dval;
      int sval;
      int sum;
      dval = int'(d[14:0]);
      if (d[15]) dval = -dval;
      sval = int'(s);
      if (s[14]) sval = sval - 32768;
      sum = dval + sval;
      return sum[15:0];
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: sr=%h required=%h", name, act, req);
      end else begin
         $display("ok   %s: sr=%h", name, act);
      end
   endtask

   // Expected value of sr, tracked from the inputs seen at each edge and from reset.
   always @(posedge clk or negedge reset) begin
      if (!reset) expected = 16'h0000;
      else        expected = addb_model(dq, se);
   end

   // Single per-cycle comparison of sr and the tied-off scan outputs.
   always @(negedge clk) begin
      if (chk_en) begin
         tests++;
         if (sr !== expected || {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4} !== 5'b0) begin
            fails++;
            $display("FAIL cycle t=%0t: sr=%h scan_out=%b required sr=%h scan_out=00000",
                     $time, sr, {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}, expected);
         end
      end
   end

   task automatic drive(input logic [15:0] d, input logic [14:0] s);
      @(posedge clk);
      #2;
      dq = d;
      se = s;
   endtask

   // Drive a vector, let one edge capture it, then check the literal expectation.
   task automatic directed(input string name, input logic [15:0] d, input logic [14:0] s,
                           input logic [15:0] req);
      drive(d, s);
      @(posedge clk);
      #1;
      check(name, sr, req);
   endtask

   initial begin
      tests = 0;
      fails = 0;
      chk_en = 1'b0;
      reset = 1'b0;
      dq = 16'h0000;
      se = 15'h0000;
      {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4} = 5'b0;
      scan_enable = 1'b0;
      test_mode = 1'b0;

      // Model pinned to hand-computed values.
      check("model_pos",   addb_model(16'h0005, 15'h0003), 16'h0008);
      check("model_neg",   addb_model(16'h8005, 15'h0003), 16'hFFFE);
      check("model_negz",  addb_model(16'h8000, 15'h0001), 16'h0001);
      check("model_wrap",  addb_model(16'h7FFF, 15'h3FFF), 16'hBFFE);
      check("model_sesgn", addb_model(16'h0000, 15'h4000), 16'hC000);

      // Reset held across edges, even with nonzero inputs.
      dq = 16'h1234;
      se = 15'h0111;
      repeat (3) @(posedge clk);
      #1;
      check("reset_hold", sr, 16'h0000);
      tests++;
      if ({scan_out0, scan_out1, scan_out2, scan_out3, scan_out4} !== 5'b0) begin
         fails++;
         $display("FAIL reset_scan: scan_out=%b required=00000",
                  {scan_out0, scan_out1, scan_out2, scan_out3, scan_out4});
      end
      #1;
      reset = 1'b1;
      chk_en = 1'b1;

      directed("add_pos",   16'h0005, 15'h0003, 16'h0008);
      directed("add_neg",   16'h8005, 15'h0003, 16'hFFFE);
      directed("se_neg",    16'h0000, 15'h4000, 16'hC000);
      directed("neg_zero",  16'h8000, 15'h0001, 16'h0001);
      directed("wrap",      16'h7FFF, 15'h3FFF, 16'hBFFE);
      directed("min_min",   16'hFFFF, 15'h4000, 16'h4001);

      // Asynchronous reset between edges, then release and reload.
      directed("pre_async", 16'h0005, 15'h0003, 16'h0008);
      #2;
      reset = 1'b0;
      #1;
      check("async_clear", sr, 16'h0000);
      @(posedge clk);
      #1;
      check("async_held", sr, 16'h0000);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("post_release", sr, 16'h0008);

      // Randomized vectors; the per-cycle compare process does the checking.
      for (int i = 0; i < 10000; i++) begin
         drive(16'($urandom), 15'($urandom));
         {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4} = 5'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
